// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bundle between the ALU/load sources, the issue stage and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int N = 32
);
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [N-1:0] alu_data;
  logic         alu_ready;
  logic         mem_valid;
  logic [4:0]   mem_rd;
  logic [N-1:0] mem_data;
  logic         mem_ready;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         regWrite;
  logic [4:0]   write_reg;
  logic [N-1:0] write_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, rs1, rs2,
    output alu_ready, mem_ready, rs1_busy, rs2_busy,
    output regWrite, write_reg, write_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, rs1, rs2,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy,
    input  regWrite, write_reg, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: one-entry ALU/load buffers, alternating grant, registered write port, busy scoreboard.
// Macro WB_BYPASS_EN: rsX_busy drops in the same cycle the write port presents rsX.
module regfile_wb_arbiter #(
  parameter int N = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic         alu_vld_q, alu_vld_d;
  logic [4:0]   alu_rd_q, alu_rd_d;
  logic [N-1:0] alu_dat_q, alu_dat_d;
  logic         mem_vld_q, mem_vld_d;
  logic [4:0]   mem_rd_q, mem_rd_d;
  logic [N-1:0] mem_dat_q, mem_dat_d;
  src_e         last_grant_q, last_grant_d;
  logic         reg_write_q, reg_write_d;
  logic [4:0]   write_reg_q, write_reg_d;
  logic [N-1:0] write_data_q, write_data_d;
  logic [31:0]  busy_q, busy_d;

  logic gnt_alu, gnt_mem;
  logic alu_rdy, mem_rdy;
  logic rs1_bsy, rs2_bsy;

  // A lone full buffer wins; on a tie the source that lost last time wins.
  always_comb begin
    gnt_alu = alu_vld_q && (!mem_vld_q || (last_grant_q == SRC_MEM));
    gnt_mem = mem_vld_q && (!alu_vld_q || (last_grant_q == SRC_ALU));
    alu_rdy = !alu_vld_q || gnt_alu;
    mem_rdy = !mem_vld_q || gnt_mem;
  end

  always_comb begin
    alu_vld_d    = alu_vld_q;
    alu_rd_d     = alu_rd_q;
    alu_dat_d    = alu_dat_q;
    mem_vld_d    = mem_vld_q;
    mem_rd_d     = mem_rd_q;
    mem_dat_d    = mem_dat_q;
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;

    if (gnt_alu) begin
      alu_vld_d    = 1'b0;
      last_grant_d = SRC_ALU;
      reg_write_d  = (alu_rd_q != 5'd0);
      write_reg_d  = alu_rd_q;
      write_data_d = alu_dat_q;
    end else if (gnt_mem) begin
      mem_vld_d    = 1'b0;
      last_grant_d = SRC_MEM;
      reg_write_d  = (mem_rd_q != 5'd0);
      write_reg_d  = mem_rd_q;
      write_data_d = mem_dat_q;
    end

    // A freed buffer may reload on the same edge it is drained.
    if (bus.alu_valid && alu_rdy) begin
      alu_vld_d = 1'b1;
      alu_rd_d  = bus.alu_rd;
      alu_dat_d = bus.alu_data;
    end
    if (bus.mem_valid && mem_rdy) begin
      mem_vld_d = 1'b1;
      mem_rd_d  = bus.mem_rd;
      mem_dat_d = bus.mem_data;
    end

    // Set is applied after clear so a same-edge reissue keeps the register pending.
    if (reg_write_q) busy_d[write_reg_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rs1_bsy = busy_q[bus.rs1];
    rs2_bsy = busy_q[bus.rs2];
`ifdef WB_BYPASS_EN
    if (reg_write_q && (write_reg_q == bus.rs1) &&
        !(bus.issue_valid && (bus.issue_rd == bus.rs1))) rs1_bsy = 1'b0;
    if (reg_write_q && (write_reg_q == bus.rs2) &&
        !(bus.issue_valid && (bus.issue_rd == bus.rs2))) rs2_bsy = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_vld_q    <= 1'b0;
      alu_rd_q     <= 5'd0;
      alu_dat_q    <= '0;
      mem_vld_q    <= 1'b0;
      mem_rd_q     <= 5'd0;
      mem_dat_q    <= '0;
      last_grant_q <= SRC_ALU;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
      busy_q       <= 32'd0;
    end else begin
      alu_vld_q    <= alu_vld_d;
      alu_rd_q     <= alu_rd_d;
      alu_dat_q    <= alu_dat_d;
      mem_vld_q    <= mem_vld_d;
      mem_rd_q     <= mem_rd_d;
      mem_dat_q    <= mem_dat_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_ready  = alu_rdy;
  assign bus.mem_ready  = mem_rdy;
  assign bus.rs1_busy   = rs1_bsy;
  assign bus.rs2_busy   = rs2_bsy;
  assign bus.regWrite   = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus pushes expected writes; a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  localparam int N = 32;
`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wb_arbiter_if #(.N(N)) bus ();
  regfile_wb_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [N-1:0] data, input int c);
    exp_t e;
    e.rd = rd; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [N-1:0] data);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = data;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [N-1:0] data);
    bus.mem_valid = 1'b1; bus.mem_rd = rd; bus.mem_data = data;
  endtask

  // Monitor: every visible write must match the head of the expectation queue, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus.regWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %0h at cycle %0d, required no write",
                 bus.write_reg, bus.write_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("write_reg", {27'd0, bus.write_reg}, {27'd0, e.rd});
        chk("write_data", bus.write_data, e.data);
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    idle();
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    #1 rst = 1'b0;
    drive_alu(5'd9, 32'h1234);   // must not be taken while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("reset_regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("reset_write_reg", {27'd0, bus.write_reg}, 32'd0);
    chk("reset_write_data", bus.write_data, 32'd0);
    chk("reset_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("reset_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    chk("reset_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Contention straight out of reset: mem wins the first tie, then strict alternation.
    c = cyc;
    push(5'd2, 32'hB000, c + 2); push(5'd1, 32'hA000, c + 3);
    push(5'd2, 32'hB001, c + 4); push(5'd1, 32'hA002, c + 5);
    push(5'd2, 32'hB003, c + 6); push(5'd1, 32'hA004, c + 7);
    push(5'd2, 32'hB005, c + 8);
    for (int i = 0; i < 6; i++) begin
      drive_alu(5'd1, 32'hA000 + i);
      drive_mem(5'd2, 32'hB000 + i);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    // Single uncontended ALU write.
    c = cyc;
    drive_alu(5'd5, 32'hDEADBEEF);
    push(5'd5, 32'hDEADBEEF, c + 2);
    #1 chk("single_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);

    // x0: accepted, arbitrated, never written; issue to x0 never marks busy.
    drive_alu(5'd0, 32'h1);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs1 = 5'd0;
    #1 chk("x0_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    @(negedge clk);
    idle();
    #1 chk("x0_busy", {31'd0, bus.rs1_busy}, 32'd0);
    repeat (3) @(negedge clk);

    // Busy scoreboard on x7.
    bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    #1 chk("busy_before_issue", {31'd0, bus.rs1_busy}, 32'd0);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1 chk("busy_after_issue", {31'd0, bus.rs1_busy}, 32'd1);
    chk("busy_rs2", {31'd0, bus.rs2_busy}, 32'd1);
    @(negedge clk);
    c = cyc;
    drive_mem(5'd7, 32'h77);
    push(5'd7, 32'h77, c + 2);
    @(negedge clk);
    idle();
    #1 chk("busy_buffered", {31'd0, bus.rs1_busy}, 32'd1);
    @(negedge clk);
    #1 chk("busy_write_cycle", {31'd0, bus.rs1_busy}, {31'd0, !BYP});
    @(negedge clk);
    #1 chk("busy_after_write", {31'd0, bus.rs1_busy}, 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    c = cyc;
    drive_mem(5'd7, 32'h78);
    push(5'd7, 32'h78, c + 2);
    @(negedge clk);
    idle();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    #1 chk("busy_reissue_write_cycle", {31'd0, bus.rs1_busy}, 32'd1);
    @(negedge clk);
    idle();
    #1 chk("busy_reissue_after", {31'd0, bus.rs1_busy}, 32'd1);
    repeat (2) @(negedge clk);

    // Backpressure: last winner was mem, so alu takes the first tie and mem stalls.
    c = cyc;
    drive_alu(5'd9, 32'h90);
    drive_mem(5'd10, 32'hA0);
    push(5'd9, 32'h90, c + 2); push(5'd10, 32'hA0, c + 3);
    push(5'd9, 32'h91, c + 4); push(5'd10, 32'hA1, c + 5);
    @(negedge clk);
    bus.alu_data = 32'h91; bus.mem_data = 32'hA1;
    #1 chk("bp_mem_stalled", {31'd0, bus.mem_ready}, 32'd0);
    chk("bp_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    @(negedge clk);
    bus.alu_valid = 1'b0;
    #1 chk("bp_mem_granted", {31'd0, bus.mem_ready}, 32'd1);
    chk("bp_alu_full", {31'd0, bus.alu_ready}, 32'd0);
    @(negedge clk);
    idle();
    #1 chk("bp_mem_stalled_again", {31'd0, bus.mem_ready}, 32'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset with both buffers full and x3 pending.
    bus.rs1 = 5'd3;
    c = cyc;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    drive_alu(5'd5, 32'h55);
    drive_mem(5'd4, 32'h44);
    push(5'd5, 32'h55, c + 2);
    @(negedge clk);
    bus.issue_valid = 1'b0; bus.mem_valid = 1'b0;
    drive_alu(5'd6, 32'h66);
    #1 chk("rst_pre_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_pre_busy", {31'd0, bus.rs1_busy}, 32'd1);
    @(negedge clk);
    idle();
    #1 chk("rst_pre_regWrite", {31'd0, bus.regWrite}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("rst_async_regWrite", {31'd0, bus.regWrite}, 32'd0);
    chk("rst_async_busy", {31'd0, bus.rs1_busy}, 32'd0);
    chk("rst_async_write_reg", {27'd0, bus.write_reg}, 32'd0);
    chk("rst_async_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("rst_async_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("rst_after_busy", {31'd0, bus.rs1_busy}, 32'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
